// File: rtl/core_tile_seq.sv
// core_tile_seq: WS/OS tile sequencer driving xmem reads, array strobes, drain wait and psum writeback.
// Define CORE_SEQ_PERF_EN to add the cyc_cnt/stall_cnt performance counters.
module core_tile_seq #(
    parameter int row    = 8,
    parameter int col    = 8,
    parameter int addr_w = 11,
    parameter int tile_w = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [addr_w-1:0] num_k,
    input  logic [tile_w-1:0] num_tiles,
    input  logic [addr_w-1:0] x_base,
    input  logic [addr_w-1:0] psum_base,
    input  logic              stall,
    output logic              xmem_cen,
    output logic              xmem_wen,
    output logic [addr_w-1:0] xmem_addr,
    output logic              psum_cen,
    output logic              psum_wen,
    output logic [addr_w-1:0] psum_addr,
    output logic              l0_wr,
    output logic              w_load,
    output logic              execute,
    output logic              ofifo_rd,
    output logic              mode_out,
    output logic              busy,
    output logic              done
`ifdef CORE_SEQ_PERF_EN
    ,
    output logic [31:0]       cyc_cnt,
    output logic [31:0]       stall_cnt
`endif
);
    localparam int cw = (addr_w > $clog2(row + col) ? addr_w : $clog2(row + col)) + 1;

    typedef enum logic [2:0] {IDLE, WLOAD, EXEC, DRAIN, WBACK, FIN} stateT;

    stateT             state, nextState;
    logic [cw-1:0]     cnt, kLen, len;
    logic [tile_w-1:0] tileCnt, tilesR;
    logic [addr_w-1:0] xPtr, pPtr;
    logic              inRun, advance, last, xAcc, pAcc;

    assign xmem_wen = 1'b1;

    // Pointers and cnt describe the next access to issue; outputs show the access just issued.
    always_comb begin
        inRun     = state inside {WLOAD, EXEC, DRAIN, WBACK};
        advance   = inRun && !stall;
        xAcc      = advance && (state == WLOAD || state == EXEC);
        pAcc      = advance && state == WBACK;
        len       = state == WLOAD ? cw'(row) : state == EXEC ? kLen :
                    state == DRAIN ? cw'(row + col - 1) : mode_out ? cw'(row) : kLen;
        last      = cnt == len - cw'(1);
        nextState = state == WLOAD ? EXEC : state == EXEC ? DRAIN : state == DRAIN ? WBACK :
                    tileCnt + tile_w'(1) != tilesR ? (mode_out ? EXEC : WLOAD) : FIN;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            kLen      <= '0;
            tileCnt   <= '0;
            tilesR    <= '0;
            xPtr      <= '0;
            pPtr      <= '0;
            xmem_cen  <= 1'b1;
            xmem_addr <= '0;
            psum_cen  <= 1'b1;
            psum_wen  <= 1'b1;
            psum_addr <= '0;
            l0_wr     <= 1'b0;
            w_load    <= 1'b0;
            execute   <= 1'b0;
            ofifo_rd  <= 1'b0;
            mode_out  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef CORE_SEQ_PERF_EN
            cyc_cnt   <= '0;
            stall_cnt <= '0;
`endif
        end else begin
            xmem_cen <= !xAcc;
            l0_wr    <= xAcc;
            w_load   <= xAcc && state == WLOAD;
            execute  <= xAcc && state == EXEC;
            psum_cen <= !pAcc;
            psum_wen <= !pAcc;
            ofifo_rd <= pAcc;
            busy     <= inRun;
            done     <= state == FIN;
            if (xAcc) begin
                xmem_addr <= xPtr;
                xPtr      <= xPtr + addr_w'(1);
            end
            if (pAcc) begin
                psum_addr <= pPtr;
                pPtr      <= pPtr + addr_w'(1);
            end
            if (state == IDLE && start) begin
                state    <= num_tiles == '0 ? FIN : mode ? EXEC : WLOAD;
                mode_out <= mode;
                kLen     <= num_k == '0 ? cw'(1) : cw'(num_k);
                tilesR   <= num_tiles;
                tileCnt  <= '0;
                cnt      <= '0;
                xPtr     <= x_base;
                pPtr     <= psum_base;
            end else if (state == FIN) begin
                state <= IDLE;
            end else if (advance) begin
                cnt <= last ? '0 : cnt + cw'(1);
                if (last) state <= nextState;
                if (last && state == WBACK) tileCnt <= tileCnt + tile_w'(1);
            end
`ifdef CORE_SEQ_PERF_EN
            cyc_cnt   <= state == IDLE && start ? '0 : cyc_cnt + 32'(inRun);
            stall_cnt <= state == IDLE && start ? '0 : stall_cnt + 32'(inRun && stall);
`endif
        end
    end
endmodule

// File: tb/tb_core_tile_seq.sv
// tb_core_tile_seq: checks core_tile_seq against an operation-list model of each run.
// Build with CORE_SEQ_PERF_EN defined to also check the performance counters.
module tb_core_tile_seq;
    localparam int ROW = 8, COL = 8, AW = 11, TW = 8;

    logic          clk = 0, reset = 1, start = 0, mode = 0, stall = 0;
    logic [AW-1:0] num_k = 0, x_base = 0, psum_base = 0;
    logic [TW-1:0] num_tiles = 0;
    logic          xmem_cen, xmem_wen, psum_cen, psum_wen, l0_wr, w_load, execute, ofifo_rd;
    logic          mode_out, busy, done;
    logic [AW-1:0] xmem_addr, psum_addr;
`ifdef CORE_SEQ_PERF_EN
    logic [31:0]   cyc_cnt, stall_cnt;
`endif

    core_tile_seq #(.row(ROW), .col(COL), .addr_w(AW), .tile_w(TW)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .num_k(num_k),
        .num_tiles(num_tiles), .x_base(x_base), .psum_base(psum_base), .stall(stall),
        .xmem_cen(xmem_cen), .xmem_wen(xmem_wen), .xmem_addr(xmem_addr),
        .psum_cen(psum_cen), .psum_wen(psum_wen), .psum_addr(psum_addr),
        .l0_wr(l0_wr), .w_load(w_load), .execute(execute), .ofifo_rd(ofifo_rd),
        .mode_out(mode_out), .busy(busy), .done(done)
`ifdef CORE_SEQ_PERF_EN
        , .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // kind: 0 weight load, 1 execute, 2 drain, 3 writeback, 4 done
    typedef struct {
        int            kind;
        logic [AW-1:0] addr;
    } opT;

    opT            plan[$];
    logic [AW-1:0] xSeen[$];
    int            checks = 0, fails = 0;
    int            busyCyc = 0, doneCnt = 0, doneAt = 0, edgeIdx = 0, pCount = 0;
    logic          modelMode = 0;
    logic [AW-1:0] lastX = 0, lastP = 0;
    longint        expCyc = 0, expStall = 0;
    localparam logic [10:0] RST_CTRL = 11'b11110000000;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void buildPlan(input logic m, input logic [AW-1:0] k, input logic [TW-1:0] t,
                                      input logic [AW-1:0] xb, input logic [AW-1:0] pb);
        int            kk;
        logic [AW-1:0] x, p;
        kk = (k == 0) ? 1 : int'(k);
        x  = xb;
        p  = pb;
        plan.delete();
        for (int i = 0; i < int'(t); i++) begin
            if (!m) for (int j = 0; j < ROW; j++) begin plan.push_back('{0, x}); x++; end
            for (int j = 0; j < kk; j++) begin plan.push_back('{1, x}); x++; end
            for (int j = 0; j < ROW + COL - 1; j++) plan.push_back('{2, '0});
            for (int j = 0; j < (m ? ROW : kk); j++) begin plan.push_back('{3, p}); p++; end
        end
        plan.push_back('{4, '0});
    endfunction

    // Model advances one step per edge; outputs are compared 1 time unit later.
    always @(posedge clk) begin
        logic [10:0] ec;
        opT          o;
        ec = RST_CTRL;
        if (reset) begin
            plan.delete();
            modelMode = 0;
            lastX = 0;
            lastP = 0;
            expCyc = 0;
            expStall = 0;
        end else if (plan.size() == 0) begin
            if (start) begin
                buildPlan(mode, num_k, num_tiles, x_base, psum_base);
                modelMode = mode;
                expCyc = 0;
                expStall = 0;
            end
        end else if (stall && plan[0].kind != 4) begin
            ec[1] = 1;
            expCyc++;
            expStall++;
        end else begin
            o = plan.pop_front();
            if (o.kind == 0 || o.kind == 1) begin
                ec[10] = 0;
                ec[6]  = 1;
                ec[5]  = o.kind == 0;
                ec[4]  = o.kind == 1;
                lastX  = o.addr;
            end
            if (o.kind == 3) begin
                ec[8] = 0;
                ec[7] = 0;
                ec[3] = 1;
                lastP = o.addr;
            end
            if (o.kind == 4) ec[0] = 1;
            else begin
                ec[1] = 1;
                expCyc++;
            end
        end
        ec[2] = modelMode;
        #1;
        chk("ctrl", {xmem_cen, xmem_wen, psum_cen, psum_wen, l0_wr, w_load, execute, ofifo_rd,
                     mode_out, busy, done}, ec);
        chk("xmem_addr", xmem_addr, lastX);
        chk("psum_addr", psum_addr, lastP);
`ifdef CORE_SEQ_PERF_EN
        chk("cyc_cnt", cyc_cnt, expCyc);
        chk("stall_cnt", stall_cnt, expStall);
`endif
        edgeIdx++;
        if (busy) busyCyc++;
        if (done) begin doneCnt++; doneAt = edgeIdx; end
        if (!xmem_cen) xSeen.push_back(xmem_addr);
        if (!psum_cen) pCount++;
    end

    // sm: 0 quiet, 1 random stall and stray starts, 2 stall on edges 10..12, 3 stray start every 5th edge
    task automatic runCmd(input logic m, input logic [AW-1:0] k, input logic [TW-1:0] t,
                          input logic [AW-1:0] xb, input logic [AW-1:0] pb, input int sm);
        @(negedge clk);
        start = 1; mode = m; num_k = k; num_tiles = t; x_base = xb; psum_base = pb;
        stall = sm == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
        busyCyc = 0; doneCnt = 0; edgeIdx = -1; pCount = 0;
        xSeen.delete();
        @(negedge clk);
        start = 0; mode = 1'($urandom); num_k = AW'($urandom); num_tiles = TW'($urandom);
        x_base = AW'($urandom); psum_base = AW'($urandom);
        for (int i = 1; i < 3000; i++) begin
            if (doneCnt > 0) break;
            stall = sm == 1 ? $urandom_range(0, 4) == 0 : sm == 2 ? (i >= 10 && i <= 12) : 1'b0;
            start = sm == 3 ? i % 5 == 0 : sm == 1 ? $urandom_range(0, 9) == 0 : 1'b0;
            @(negedge clk);
        end
        stall = 0;
        start = 0;
        chk("run_done_within_bound", doneCnt > 0, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 0;
        @(negedge clk);

        runCmd(0, 4, 1, 11'h010, 11'h100, 0);
        chk("ws_busy_cycles", busyCyc, 31);
        chk("ws_done_edge", doneAt, 32);
        chk("ws_x_reads", xSeen.size(), 12);
        chk("ws_x_first", xSeen[0], 11'h010);
        chk("ws_x_last", xSeen[11], 11'h01B);
        chk("ws_psum_writes", pCount, 4);
        chk("ws_psum_last", psum_addr, 11'h103);

        runCmd(1, 3, 2, 11'h000, 11'h000, 0);
        chk("os_busy_cycles", busyCyc, 52);
        chk("os_done_count", doneCnt, 1);
        chk("os_x_reads", xSeen.size(), 6);
        chk("os_x_last", xSeen[5], 11'h005);
        chk("os_psum_writes", pCount, 16);
        chk("os_psum_last", psum_addr, 11'h00F);

        runCmd(0, 4, 1, 11'h010, 11'h100, 2);
        chk("stall_busy_cycles", busyCyc, 34);
        chk("stall_done_edge", doneAt, 35);
        chk("stall_x_reads", xSeen.size(), 12);
        chk("stall_x_reissue", xSeen[9], 11'h019);
`ifdef CORE_SEQ_PERF_EN
        chk("stall_cyc_cnt", cyc_cnt, 34);
        chk("stall_stall_cnt", stall_cnt, 3);
`endif

        runCmd(1, 4, 1, 11'h7FE, 11'h000, 0);
        chk("wrap_x_reads", xSeen.size(), 4);
        chk("wrap_x0", xSeen[0], 11'h7FE);
        chk("wrap_x1", xSeen[1], 11'h7FF);
        chk("wrap_x2", xSeen[2], 11'h000);
        chk("wrap_x3", xSeen[3], 11'h001);

        runCmd(0, 4, 0, 11'h010, 11'h100, 0);
        chk("zero_done_edge", doneAt, 1);
        chk("zero_busy_cycles", busyCyc, 0);
        chk("zero_x_reads", xSeen.size(), 0);
        chk("zero_psum_writes", pCount, 0);

        runCmd(0, 4, 1, 11'h010, 11'h100, 3);
        repeat (6) @(negedge clk);
        chk("restart_ignored_done", doneCnt, 1);
        chk("restart_ignored_busy", busyCyc, 31);

        @(negedge clk);
        start = 1; mode = 1; num_k = 4; num_tiles = 1; x_base = 11'h020; psum_base = 11'h200;
        doneCnt = 0; pCount = 0;
        @(negedge clk);
        start = 0;
        repeat (10) @(negedge clk);
        reset = 1;
        #1;
        chk("async_reset_ctrl", {xmem_cen, xmem_wen, psum_cen, psum_wen, l0_wr, w_load, execute,
                                 ofifo_rd, mode_out, busy, done}, RST_CTRL);
        chk("async_reset_xaddr", xmem_addr, 0);
        chk("async_reset_paddr", psum_addr, 0);
        @(negedge clk);
        reset = 0;
        repeat (30) @(negedge clk);
        chk("reset_no_done", doneCnt, 0);
        chk("reset_no_psum", pCount, 0);
        runCmd(0, 4, 1, 11'h010, 11'h100, 0);
        chk("after_reset_busy", busyCyc, 31);

        for (int r = 0; r < 25; r++)
            runCmd(1'($urandom), AW'($urandom_range(0, 5)), TW'($urandom_range(0, 3)),
                   AW'($urandom), AW'($urandom), 1);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/core_tile_seq.md
Name: core_tile_seq

Overview:
- Parametrised tile sequencer for the systolic core.
- Replaces hand-built per-cycle instruction streams: after one start command it generates the activation/weight SRAM read sequence, the array load/execute strobes, the drain wait and the psum SRAM writeback for a run of tiles.
- Supports weight-stationary (WS) and output-stationary (OS) modes.
- Sits between the testbench/host and the core's memory and array control fields.

Parameters:
- row, 8, array rows (L0 depth per weight load, OS writeback length)
- col, 8, array columns (used for drain length)
- addr_w, 11, SRAM address width
- tile_w, 8, width of the tile count

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- start  input  1  one-cycle command; sampled only in IDLE
- mode  input  1  0 = WS, 1 = OS; latched at start
- num_k  input  addr_w  activation vectors per tile; 0 treated as 1; latched at start
- num_tiles  input  tile_w  tiles in the run; latched at start
- x_base  input  addr_w  first xmem address
- psum_base  input  addr_w  first psum address
- stall  input  1  freeze request
- xmem_cen  output  1  xmem chip enable, active low
- xmem_wen  output  1  xmem write enable, active low; tied 1 (read only)
- xmem_addr  output  addr_w  xmem address
- psum_cen  output  1  psum chip enable, active low
- psum_wen  output  1  psum write enable, active low
- psum_addr  output  addr_w  psum address
- l0_wr  output  1  push xmem data into L0
- w_load  output  1  high during weight-load cycles
- execute  output  1  high during activation cycles
- ofifo_rd  output  1  pop OFIFO toward psum SRAM
- mode_out  output  1  latched mode
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse at run completion

Behaviour:
- All outputs are registered.
- Reset values: xmem_cen = xmem_wen = psum_cen = psum_wen = 1; all other outputs and both address pointers = 0; state = IDLE.
- States and transitions:
  - IDLE --start--> WLOAD if WS, or EXEC if OS. If num_tiles == 0, go to FIN instead.
  - WLOAD: row cycles. xmem_cen = 0, l0_wr = 1, w_load = 1. Then go to EXEC.
  - EXEC: num_k cycles. xmem_cen = 0, l0_wr = 1, execute = 1. Then go to DRAIN.
  - DRAIN: row+col-1 cycles, no memory access. Then go to WBACK.
  - WBACK: num_k cycles (WS) or row cycles (OS). psum_cen = psum_wen = 0, ofifo_rd = 1.
  - After WBACK: the tile counter increments. If tiles remain, go to WLOAD (WS) or EXEC (OS); otherwise go to FIN.
  - FIN: done = 1 for one cycle, busy = 0; return to IDLE.
- Latency: start sampled at edge 0 means first access outputs are valid after edge 1.
- Addressing:
  - xmem_addr starts at x_base and increments after every WLOAD/EXEC access.
  - psum_addr starts at psum_base and increments after every WBACK write.
  - Both pointers continue across tiles and wrap modulo 2^addr_w.
- Stall: while stall = 1, state, counters and pointers hold. CEN/WEN go to 1 and strobes go to 0 for those cycles. Access resumes unchanged in the cycle after stall falls.
- start while busy is ignored. stall in IDLE has no effect. Inputs other than stall are ignored after start.
- Reset mid-run: immediate return to reset values. No done pulse. No residual SRAM access.

Optional Feature:
- Macro: CORE_SEQ_PERF_EN.
- Defined: adds outputs cyc_cnt[31:0] and stall_cnt[31:0].
  - Both clear on an accepted start.
  - cyc_cnt counts busy cycles.
  - stall_cnt counts busy cycles with stall = 1.
  - Both hold after done; both reset to 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- WS, num_k=4, num_tiles=1, x_base=0x010, psum_base=0x100 -> xmem reads 0x010..0x017 with w_load, then 0x018..0x01B with execute, 15 idle cycles, psum writes 0x100..0x103, done on the 32nd cycle after start; busy high for exactly 31 cycles.
- OS, num_k=3, num_tiles=2, bases 0 -> xmem 0x000..0x005, psum 0x000..0x00F, 26 cycles per tile, 52 busy cycles, a single done pulse.
- WS run from the first test with stall held high for 3 cycles during EXEC at address 0x019 -> no access during the stall, 0x019 reissued after stall falls, busy extended to 34 cycles; with CORE_SEQ_PERF_EN, cyc_cnt = 34 and stall_cnt = 3.
- OS, x_base=0x7FE, num_k=4 -> xmem_addr sequence 0x7FE, 0x7FF, 0x000, 0x001.
- num_tiles=0 -> done pulse one cycle after start; xmem_cen and psum_cen stay 1.
- Second start pulse issued during busy -> ignored. Reset asserted during DRAIN -> all outputs return to reset values asynchronously, no done pulse; a new start then runs normally.
